store_checker: RTL and testbench
================================

# store_checker

Synthesizable store-bus checker sitting directly downstream of the single-cycle processor `top`. It observes `MemWrite`/`DataAdr`/`WriteData` on every clock and compares each store against a parameterised table of expected words at consecutive addresses. It reports pass/fail, error cause and the failing store, so self-checking runs (VADD/VMUL/VADDH/VMULH results) work on FPGA and in lint-clean simulation without a behavioural bench.

## Interface
Parameters:
- `N_CHECKS`, 4: number of expected stores, 1..16.
- `BASE_ADDR`, 32'd100: address of expected store 0; store i is at `BASE_ADDR + 4*i`.
- `EXP_VALS`, {32'h00003A80, 32'h00004040, 32'h45c8c700, 32'h4585e600}: packed `32*N_CHECKS` bits; entry i is `EXP_VALS[32*i +: 32]`.
- `TIMEOUT`, 1000: maximum cycles in RUN without an accepted store, ≥2.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — synchronous, active-high.
- `MemWrite`  in  1  — store strobe from the core.
- `DataAdr`  in  32  — store address.
- `WriteData`  in  32  — store data.
- `done`  out  1  — state is PASS or FAIL.
- `pass`  out  1  — state is PASS.
- `fail`  out  1  — state is FAIL.
- `err_code`  out  2  — 00 none, 01 data mismatch, 10 unexpected address, 11 timeout.
- `checks`  out  5  — stores compared so far.
- `errors`  out  5  — errors counted, saturating at 31.
- `fail_addr`  out  32  — `DataAdr` of the first failing store (0 on timeout).
- `fail_data`  out  32  — `WriteData` of the first failing store (0 on timeout).

## Operation
- States: RUN, PASS, FAIL. Reset → RUN, `idx`=0, timer=0. Every output resets to 0.
- RUN, `MemWrite`=1, `DataAdr == BASE_ADDR+4*idx`: `checks`+1 and timer←0.
  - Data equal to entry idx: `idx`+1. If `idx` was `N_CHECKS-1`, go to PASS (with `errors`=0) or FAIL (with `errors`>0).
  - Data not equal: `err_code`=01, `errors`+1.
- RUN, `MemWrite`=1, any other address: `err_code`=10, `errors`+1; `idx` and `checks` unchanged; timer←0.
- RUN, `MemWrite`=0: timer+1. When timer reaches `TIMEOUT-1` and increments: go to FAIL with `err_code`=11.
- `err_code`, `fail_addr` and `fail_data` latch on the first error only. Later errors do not overwrite them.
- PASS/FAIL are terminal until reset. Stores in these states are ignored and all outputs hold.
- Address compare uses the full 32 bits; misaligned addresses count as unexpected.

## Timing
- All outputs are registered. A store sampled at edge k is reflected in the outputs after edge k, i.e. one cycle of latency.
- Back-to-back stores, one per cycle, are each evaluated; there is no stall and no handshake back to the core.
- A store in the same cycle the timer would expire takes priority: it is evaluated and the timer clears.
- `reset` asserted mid-run clears all state at that edge, regardless of `MemWrite`.
- Error on the final expected store (non-continue mode): state goes to FAIL, never PASS.

## Configuration
- `STORE_CHECKER_CONTINUE_EN` defined:
  - Data-mismatch and unexpected-address errors do not terminate the run.
  - A mismatching store at the expected address still advances `idx`.
  - The run ends at PASS or FAIL after the last expected address is stored.
  - Timeout still goes to FAIL immediately.
- Macro undefined: the first error of any kind goes to FAIL at that edge; `errors` is then 1.

## Test plan
- Stores 4585e600@100, 45c8c700@104, 00004040@108, 00003A80@112 on consecutive cycles → one cycle after the last: `pass`=1, `checks`=4, `errors`=0, `err_code`=00.
- Store 4585e601@100 (macro undefined) → `fail`=1, `err_code`=01, `fail_addr`=100, `fail_data`=4585e601, `checks`=1.
- Store to address 96 first (macro undefined) → `fail`=1, `err_code`=10, `checks`=0, `fail_addr`=96.
- With `TIMEOUT`=8 and no stores after reset → `fail`=1, `err_code`=11 exactly 8 cycles after reset deassert; a store at cycle 7 instead clears the timer.
- With `STORE_CHECKER_CONTINUE_EN` defined, a bad value @104 and the rest correct → FAIL after the 112 store, `errors`=1, `checks`=4, `fail_addr`=104.
- `reset` pulsed after two good stores, then the full sequence → `pass`=1 and `checks`=4 (not 6).

Source files
------------

// File: rtl/store_checker.sv
// store_checker: compares core stores against a table of expected words at consecutive addresses
// Ports: clk, reset (sync, active-high); MemWrite/DataAdr/WriteData observed store bus;
// done/pass/fail final status; err_code 00 none, 01 data, 10 address, 11 timeout;
// checks = stores compared, errors = saturating error count; fail_addr/fail_data = first failing store.
// Build option: STORE_CHECKER_CONTINUE_EN keeps running through data/address errors.
module store_checker #(
    parameter int unsigned N_CHECKS = 4,
    parameter logic [31:0] BASE_ADDR = 32'd100,
    parameter logic [32*N_CHECKS-1:0] EXP_VALS = {32'h00003A80, 32'h00004040, 32'h45c8c700, 32'h4585e600},
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic [1:0]  err_code,
    output logic [4:0]  checks,
    output logic [4:0]  errors,
    output logic [31:0] fail_addr,
    output logic [31:0] fail_data
);
    localparam int TW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL} state_t;
    state_t state_q, state_d;
    logic [4:0] idx_q, idx_d, checks_q, checks_d, errors_q, errors_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0] err_code_q, err_code_d;
    logic [31:0] fail_addr_q, fail_addr_d, fail_data_q, fail_data_d;
    logic [31:0] exp_addr, exp_data;
    logic hit, mismatch, err, last, expire;
    always_comb begin
        exp_data = '0;
        for (int i = 0; i < int'(N_CHECKS); i++)
            if (idx_q == 5'(i)) exp_data = EXP_VALS[32*i +: 32];
        exp_addr = BASE_ADDR + {25'd0, idx_q, 2'b00};
        hit = MemWrite && DataAdr == exp_addr;
        mismatch = hit && WriteData != exp_data;
        err = (MemWrite && !hit) || mismatch;
        last = idx_q == 5'(N_CHECKS - 1);
        expire = !MemWrite && timer_q == TW'(TIMEOUT - 1);
        state_d = state_q;
        idx_d = idx_q;
        timer_d = timer_q;
        checks_d = checks_q;
        errors_d = errors_q;
        err_code_d = err_code_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        if (state_q == S_RUN) begin
            timer_d = MemWrite ? '0 : timer_q + 1'b1;
            checks_d = hit ? checks_q + 1'b1 : checks_q;
            if (err) begin
                errors_d = (errors_q == 5'd31) ? errors_q : errors_q + 1'b1;
                if (err_code_q == 2'b00) begin
                    err_code_d = mismatch ? 2'b01 : 2'b10;
                    fail_addr_d = DataAdr;
                    fail_data_d = WriteData;
                end
            end
`ifdef STORE_CHECKER_CONTINUE_EN
            if (hit) idx_d = idx_q + 1'b1;
            if (hit && last) state_d = (errors_d == 5'd0) ? S_PASS : S_FAIL;
`else
            if (hit && !mismatch) idx_d = idx_q + 1'b1;
            if (err) state_d = S_FAIL;
            else if (hit && last) state_d = S_PASS;
`endif
            if (expire) begin
                state_d = S_FAIL;
                if (err_code_q == 2'b00) err_code_d = 2'b11;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            idx_q <= '0;
            timer_q <= '0;
            checks_q <= '0;
            errors_q <= '0;
            err_code_q <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            timer_q <= timer_d;
            checks_q <= checks_d;
            errors_q <= errors_d;
            err_code_q <= err_code_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end
    assign done = state_q != S_RUN;
    assign pass = state_q == S_PASS;
    assign fail = state_q == S_FAIL;
    assign err_code = err_code_q;
    assign checks = checks_q;
    assign errors = errors_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
endmodule

// File: tb/tb_store_checker.sv
// tb_store_checker: table-driven scoreboard bench for store_checker (TIMEOUT=8)
module tb_store_checker;
    logic clk = 1'b0, reset = 1'b1, MemWrite = 1'b0;
    logic [31:0] DataAdr = '0, WriteData = '0;
    logic done, pass, fail;
    logic [1:0] err_code;
    logic [4:0] checks, errors;
    logic [31:0] fail_addr, fail_data;
    localparam logic [31:0] E0 = 32'h4585e600, E1 = 32'h45c8c700, E2 = 32'h00004040, E3 = 32'h00003A80;
    store_checker #(.TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .done(done), .pass(pass), .fail(fail), .err_code(err_code), .checks(checks),
        .errors(errors), .fail_addr(fail_addr), .fail_data(fail_data)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic rst, mw;
        logic [31:0] adr, wd;
        logic dn, ps, fl;
        logic [1:0] ec;
        logic [4:0] ck, er;
        logic [31:0] fa, fd;
    } vec_t;
    vec_t tbl[$];
    vec_t sb[$];
    int n_run = 0, n_fail = 0;
    function automatic vec_t v(logic rst, logic mw, logic [31:0] adr, logic [31:0] wd, logic ps, logic fl,
                               logic [1:0] ec, logic [4:0] ck, logic [4:0] er, logic [31:0] fa, logic [31:0] fd);
        vec_t r;
        r.rst = rst; r.mw = mw; r.adr = adr; r.wd = wd;
        r.dn = ps | fl; r.ps = ps; r.fl = fl; r.ec = ec; r.ck = ck; r.er = er; r.fa = fa; r.fd = fd;
        return r;
    endfunction
    function automatic vec_t rv();
        return v(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    endfunction
    task automatic chk(input string nm, input int k, input logic [31:0] a, input logic [31:0] e);
        n_run++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h want %h", nm, k, a, e);
        end
    endtask
    task automatic apply(input vec_t x, input int k);
        vec_t e;
        @(negedge clk);
        reset = x.rst; MemWrite = x.mw; DataAdr = x.adr; WriteData = x.wd;
        sb.push_back(x);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("done", k, 32'(done), 32'(e.dn));
        chk("pass", k, 32'(pass), 32'(e.ps));
        chk("fail", k, 32'(fail), 32'(e.fl));
        chk("err_code", k, 32'(err_code), 32'(e.ec));
        chk("checks", k, 32'(checks), 32'(e.ck));
        chk("errors", k, 32'(errors), 32'(e.er));
        chk("fail_addr", k, fail_addr, e.fa);
        chk("fail_data", k, fail_data, e.fd);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        tbl.push_back(rv());
        tbl.push_back(v(0, 1, 100, E0, 0, 0, 2'b00, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 104, E1, 0, 0, 2'b00, 2, 0, 0, 0));
        tbl.push_back(v(0, 1, 108, E2, 0, 0, 2'b00, 3, 0, 0, 0));
        tbl.push_back(v(0, 1, 112, E3, 1, 0, 2'b00, 4, 0, 0, 0));
        tbl.push_back(v(0, 1, 100, 32'hdead, 1, 0, 2'b00, 4, 0, 0, 0));
        tbl.push_back(rv());
        tbl.push_back(v(0, 1, 100, E0, 0, 0, 2'b00, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 104, E1, 0, 0, 2'b00, 2, 0, 0, 0));
        tbl.push_back(v(1, 1, 108, E2, 0, 0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 100, E0, 0, 0, 2'b00, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 104, E1, 0, 0, 2'b00, 2, 0, 0, 0));
        tbl.push_back(v(0, 1, 108, E2, 0, 0, 2'b00, 3, 0, 0, 0));
        tbl.push_back(v(0, 1, 112, E3, 1, 0, 2'b00, 4, 0, 0, 0));
        tbl.push_back(rv());
`ifdef STORE_CHECKER_CONTINUE_EN
        tbl.push_back(v(0, 1, 100, E0, 0, 0, 2'b00, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 104, 32'h45c8c701, 0, 0, 2'b01, 2, 1, 104, 32'h45c8c701));
        tbl.push_back(v(0, 1, 108, E2, 0, 0, 2'b01, 3, 1, 104, 32'h45c8c701));
        tbl.push_back(v(0, 1, 112, E3, 0, 1, 2'b01, 4, 1, 104, 32'h45c8c701));
        tbl.push_back(rv());
        tbl.push_back(v(0, 1, 96, 32'h5, 0, 0, 2'b10, 0, 1, 96, 32'h5));
        tbl.push_back(v(0, 1, 101, E0, 0, 0, 2'b10, 0, 2, 96, 32'h5));
        tbl.push_back(v(0, 1, 100, E0, 0, 0, 2'b10, 1, 2, 96, 32'h5));
`else
        tbl.push_back(v(0, 1, 100, 32'h4585e601, 0, 1, 2'b01, 1, 1, 100, 32'h4585e601));
        tbl.push_back(v(0, 1, 96, 32'h7, 0, 1, 2'b01, 1, 1, 100, 32'h4585e601));
        tbl.push_back(rv());
        tbl.push_back(v(0, 1, 96, 32'h5, 0, 1, 2'b10, 0, 1, 96, 32'h5));
        tbl.push_back(rv());
        tbl.push_back(v(0, 1, 101, E0, 0, 1, 2'b10, 0, 1, 101, E0));
        tbl.push_back(rv());
        tbl.push_back(v(0, 1, 100, E0, 0, 0, 2'b00, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 104, E1, 0, 0, 2'b00, 2, 0, 0, 0));
        tbl.push_back(v(0, 1, 108, E2, 0, 0, 2'b00, 3, 0, 0, 0));
        tbl.push_back(v(0, 1, 112, 32'h0, 0, 1, 2'b01, 4, 1, 112, 32'h0));
`endif
        foreach (tbl[i]) apply(tbl[i], i);
        apply(rv(), 1000);
        for (int i = 1; i <= 7; i++) apply(v(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0), 1000 + i);
        apply(v(0, 0, 0, 0, 0, 1, 2'b11, 0, 0, 0, 0), 1008);
        apply(v(0, 1, 100, E1, 0, 1, 2'b11, 0, 0, 0, 0), 1009);
        apply(rv(), 2000);
        for (int i = 1; i <= 7; i++) apply(v(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0), 2000 + i);
        apply(v(0, 1, 100, E0, 0, 0, 2'b00, 1, 0, 0, 0), 2008);
        for (int i = 1; i <= 7; i++) apply(v(0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0), 2008 + i);
        apply(v(0, 0, 0, 0, 0, 1, 2'b11, 1, 0, 0, 0), 2016);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
